// File: rtl/aes256_key_sched_ctrl.sv
// aes256_key_sched_ctrl: expands one AES-256 key into RK0..RK14 and serves them through a registered read port
module aes256_key_sched_ctrl #(
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid_i,
  output logic               key_ready_o,
  input  logic [255:0]       key_in_i,
  input  logic               clear_i,
  output logic               busy_o,
  output logic               keys_valid_o,
  input  logic               rk_rd_en_i,
  input  logic [IDX_W-1:0]   rk_rd_idx_i,
  output logic               rk_rd_vld_o,
  output logic [127:0]       rk_rd_data_o
);
  localparam int NUM_RK = 15;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, v;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    v    = gmul(gmul(x240, x12), x2);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  state_e             state_q;
  logic [IDX_W-1:0]   round_q;
  logic [255:0]       wk_q, wk_d;
  logic [127:0]       rk_q [NUM_RK+1];
  logic [127:0]       rk_d, rk_rd_data_q;
  logic               key_ready_q, busy_q, keys_valid_q, rk_rd_vld_q;
  logic [7:0]         rcon;
  logic [31:0]        t, o0, o1, o2, o3;
  // ExpandKey: even rounds rotate+substitute+rcon the last word, odd rounds substitute only
  always_comb begin
    rcon = 8'h01 << (round_q[3:1] - 3'd1);
    t    = round_q[0] ? subw(wk_q[31:0]) : subw({wk_q[23:0], wk_q[31:24]}) ^ {rcon, 24'h0};
    o0   = wk_q[255:224] ^ t;
    o1   = wk_q[223:192] ^ o0;
    o2   = wk_q[191:160] ^ o1;
    o3   = wk_q[159:128] ^ o2;
    rk_d = {o0, o1, o2, o3};
    wk_d = {wk_q[127:0], rk_d};
  end
  // Control FSM, round-key file and read port; entry 15 is never written so it always reads as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      round_q      <= '0;
      wk_q         <= '0;
      for (int i = 0; i < NUM_RK + 1; i++) rk_q[i] <= '0;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      rk_rd_vld_q  <= 1'b0;
      rk_rd_data_q <= '0;
    end else if (clear_i) begin
      state_q      <= IDLE;
      round_q      <= '0;
      wk_q         <= '0;
      for (int i = 0; i < NUM_RK + 1; i++) rk_q[i] <= '0;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      rk_rd_vld_q  <= 1'b0;
    end else begin
      rk_rd_vld_q <= rk_rd_en_i;
      if (rk_rd_en_i) rk_rd_data_q <= rk_q[rk_rd_idx_i];
      if (key_valid_i && key_ready_q) begin
        rk_q[0]      <= key_in_i[255:128];
        rk_q[1]      <= key_in_i[127:0];
        wk_q         <= key_in_i;
        round_q      <= IDX_W'(2);
        state_q      <= EXPAND;
        key_ready_q  <= 1'b0;
        busy_q       <= 1'b1;
        keys_valid_q <= 1'b0;
      end else if (state_q == EXPAND) begin
        rk_q[round_q] <= rk_d;
        wk_q          <= wk_d;
        round_q       <= round_q + IDX_W'(1);
        if (round_q == IDX_W'(14)) begin
          state_q      <= DONE;
          key_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
          keys_valid_q <= 1'b1;
        end
      end
    end
  end
  assign key_ready_o  = key_ready_q;
  assign busy_o       = busy_q;
  assign keys_valid_o = keys_valid_q;
  assign rk_rd_vld_o  = rk_rd_vld_q;
  assign rk_rd_data_o = rk_rd_data_q;
endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// tb_aes256_key_sched_ctrl: scoreboard bench for the AES-256 key schedule controller
module tb_aes256_key_sched_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid_i;
  logic         key_ready_o;
  logic [255:0] key_in_i;
  logic         clear_i;
  logic         busy_o;
  logic         keys_valid_o;
  logic         rk_rd_en_i;
  logic [3:0]   rk_rd_idx_i;
  logic         rk_rd_vld_o;
  logic [127:0] rk_rd_data_o;
  localparam logic [255:0] K1   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R141 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [255:0] K2   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R142 = 128'hfe4890d1e6188d0b046df344706c631e;
  int           total = 0;
  int           bad = 0;
  int           n;
  logic         mon_on = 1'b0;
  logic         en_seen = 1'b0;
  logic [127:0] sbq [$];
  logic [127:0] m_rk [15];
  aes256_key_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key_valid_i(key_valid_i), .key_ready_o(key_ready_o),
    .key_in_i(key_in_i), .clear_i(clear_i), .busy_o(busy_o), .keys_valid_o(keys_valid_o),
    .rk_rd_en_i(rk_rd_en_i), .rk_rd_idx_i(rk_rd_idx_i), .rk_rd_vld_o(rk_rd_vld_o),
    .rk_rd_data_o(rk_rd_data_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] v, s, c;
    v = '0;
    c = 8'h63;
    for (int y = 1; y < 256; y++) if (mul(x, 8'(y)) == 8'h01) v = 8'(y);
    for (int i = 0; i < 8; i++) s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
    return s;
  endfunction
  function automatic logic [31:0] sw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction
  task automatic expand(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = sw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) t = sw(t);
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  task automatic load(input logic [255:0] k);
    @(negedge clk);
    key_valid_i = 1'b1;
    key_in_i = k;
    @(posedge clk);
    #1 key_valid_i = 1'b0;
  endtask
  task automatic wait_done(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (!keys_valid_o && cnt < 40) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
  endtask
  task automatic rd(input logic [3:0] idx, input logic [127:0] e);
    @(negedge clk);
    rk_rd_en_i = 1'b1;
    rk_rd_idx_i = idx;
    sbq.push_back(e);
  endtask
  task automatic rd_off();
    @(negedge clk);
    rk_rd_en_i = 1'b0;
  endtask
  always @(posedge clk) en_seen = rk_rd_en_i;
  always @(negedge clk) begin
    if (mon_on) begin
      chk("rd_vld", 128'(rk_rd_vld_o), 128'(en_seen));
      if (rk_rd_vld_o) begin
        if (sbq.size() == 0) chk("sb_underflow", 128'(1), 128'(0));
        else chk("rd_data", rk_rd_data_o, sbq.pop_front());
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    key_valid_i = 1'b0;
    key_in_i = '0;
    clear_i = 1'b0;
    rk_rd_en_i = 1'b0;
    rk_rd_idx_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 128'(key_ready_o), 128'(1));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_kv", 128'(keys_valid_o), 128'(0));
    chk("rst_vld", 128'(rk_rd_vld_o), 128'(0));
    chk("rst_data", rk_rd_data_o, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;
    expand(K1);
    load(K1);
    chk("t1_busy_start", 128'(busy_o), 128'(1));
    chk("t1_ready_start", 128'(key_ready_o), 128'(0));
    wait_done(n);
    chk("t1_lat", 128'(n), 128'(13));
    chk("t1_ready", 128'(key_ready_o), 128'(1));
    chk("t1_busy", 128'(busy_o), 128'(0));
    for (int i = 0; i < 16; i++) begin
      if (i == 15) rd(4'(i), 128'h0);
      else if (i == 14) rd(4'(i), R141);
      else rd(4'(i), m_rk[i]);
    end
    rd(4'd14, R141);
    rd_off();
    repeat (2) @(negedge clk);
    chk("t6_hold", rk_rd_data_o, R141);
    rd(4'd3, m_rk[3]);
    rd_off();
    rd(4'd7, m_rk[7]);
    rd_off();
    load(K2);
    wait_done(n);
    chk("t2_lat", 128'(n), 128'(13));
    rd(4'd0, K2[255:128]);
    rd(4'd1, K2[127:0]);
    rd(4'd14, R142);
    rd_off();
    @(negedge clk);
    key_valid_i = 1'b1;
    key_in_i = K1;
    @(posedge clk);
    #1 key_in_i = K2;
    n = 0;
    @(negedge clk);
    while (!keys_valid_o && n < 40) begin
      chk("t3_ready", 128'(key_ready_o), 128'(0));
      chk("t3_busy", 128'(busy_o), 128'(1));
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("t3_lat1", 128'(n), 128'(13));
    @(posedge clk);
    #1 key_valid_i = 1'b0;
    chk("t3_reaccept", 128'(busy_o), 128'(1));
    wait_done(n);
    chk("t3_lat2", 128'(n), 128'(13));
    rd(4'd14, R142);
    rd(4'd1, K2[127:0]);
    rd_off();
    load(K1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    clear_i = 1'b1;
    @(posedge clk);
    #1 clear_i = 1'b0;
    chk("t4_busy", 128'(busy_o), 128'(0));
    chk("t4_ready", 128'(key_ready_o), 128'(1));
    chk("t4_kv", 128'(keys_valid_o), 128'(0));
    for (int i = 0; i < 15; i++) rd(4'(i), 128'h0);
    rd_off();
    repeat (10) @(negedge clk);
    chk("t4_kv_later", 128'(keys_valid_o), 128'(0));
    load(K1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 128'(busy_o), 128'(0));
    chk("t5_ready", 128'(key_ready_o), 128'(1));
    chk("t5_kv", 128'(keys_valid_o), 128'(0));
    chk("t5_data", rk_rd_data_o, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    load(K1);
    wait_done(n);
    chk("t5_lat", 128'(n), 128'(13));
    rd(4'd14, R141);
    rd(4'd5, m_rk[5]);
    rd(4'd15, 128'h0);
    rd_off();
    repeat (2) @(negedge clk);
    chk("sb_empty", 128'(sbq.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
